// File: rtl/cmp_arbiter_seq_if.sv
// Request/response bundle for the shared magnitude-compare engine.
// Handshake: a transfer happens on a rising edge where valid and ready are both high;
// valid must not wait on ready, and the sender holds its payload stable until the transfer.
interface cmp_arbiter_seq_if #(
    parameter int WIDTH = 16,
    parameter int NREQ  = 4
);
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic                  rsp_agb;
    logic                  rsp_aeb;
    logic                  rsp_alb;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_agb, rsp_aeb, rsp_alb
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_agb, rsp_aeb, rsp_alb
    );
endinterface

// File: rtl/cmp_arbiter_seq.sv
// Round-robin arbitrated unsigned comparator: one 4-bit subtractor walks the granted
// operands MSB nibble first and stops at the first unequal nibble.
module cmp_arbiter_seq #(
    parameter int WIDTH = 16,
    parameter int NREQ  = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    cmp_arbiter_seq_if.slave          bus,
    output logic [1:0]                dbg_state_o,
    output logic [$clog2(NREQ)-1:0]   dbg_rr_ptr_o
);
    localparam int IDW  = $clog2(NREQ);
    localparam int NNIB = WIDTH / 4;
    localparam int KW   = (NNIB > 1) ? $clog2(NNIB) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CMP  = 2'd1,
        S_RESP = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [KW-1:0]      k_q, k_d;
    logic [WIDTH-1:0]   op_a_q, op_a_d;
    logic [WIDTH-1:0]   op_b_q, op_b_d;
    logic [IDW-1:0]     rsp_id_q, rsp_id_d;
    logic               agb_q, agb_d;
    logic               aeb_q, aeb_d;
    logic               alb_q, alb_d;

    logic               found;
    logic [IDW-1:0]     grant_idx;
    logic [IDW-1:0]     cand;
    logic [NREQ-1:0]    req_ready;
    logic               accept;
    logic [3:0]         nib_a;
    logic [3:0]         nib_b;
    logic [4:0]         diff;

    // Rotating priority search: first valid requester at or after rr_ptr wins.
    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = IDW'((32'(rr_ptr_q) + 32'(i)) % NREQ);
            if (!found && bus.req_valid[cand]) begin
                found     = 1'b1;
                grant_idx = cand;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state_q == S_IDLE && rst_n && found) begin
            req_ready = NREQ'(1) << grant_idx;
        end
    end

    assign accept = |(bus.req_valid & req_ready);

    // Subtract-based nibble compare: carry set means a >= b, zero difference means equal.
    assign nib_a = op_a_q[{k_q, 2'b00} +: 4];
    assign nib_b = op_b_q[{k_q, 2'b00} +: 4];
    assign diff  = {1'b0, nib_a} + {1'b0, ~nib_b} + 5'd1;

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        k_d      = k_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        rsp_id_d = rsp_id_q;
        agb_d    = agb_q;
        aeb_d    = aeb_q;
        alb_d    = alb_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_a_d   = bus.req_a[grant_idx*WIDTH +: WIDTH];
                    op_b_d   = bus.req_b[grant_idx*WIDTH +: WIDTH];
                    rsp_id_d = grant_idx;
                    rr_ptr_d = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
                    k_d      = KW'(NNIB - 1);
                    state_d  = S_CMP;
                end
            end
            S_CMP: begin
                if (diff[3:0] != 4'd0) begin
                    agb_d   = diff[4];
                    alb_d   = ~diff[4];
                    aeb_d   = 1'b0;
                    state_d = S_RESP;
                end else if (k_q == '0) begin
                    agb_d   = 1'b0;
                    alb_d   = 1'b0;
                    aeb_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    k_d = k_q - 1'b1;
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            rr_ptr_q <= '0;
            k_q      <= '0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            rsp_id_q <= '0;
            agb_q    <= 1'b0;
            aeb_q    <= 1'b0;
            alb_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            k_q      <= k_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            rsp_id_q <= rsp_id_d;
            agb_q    <= agb_d;
            aeb_q    <= aeb_d;
            alb_q    <= alb_d;
        end
    end

    // Response side comes straight from registers, so rsp_ready never reaches an output.
    assign bus.req_ready = req_ready;
    assign bus.rsp_valid = (state_q == S_RESP);
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_agb   = agb_q;
    assign bus.rsp_aeb   = aeb_q;
    assign bus.rsp_alb   = alb_q;

    assign dbg_state_o   = state_q;
    assign dbg_rr_ptr_o  = rr_ptr_q;
endmodule

// File: tb/tb_cmp_arbiter_seq.sv
// Scoreboarded bench for cmp_arbiter_seq: reset, early/full nibble walks, round robin,
// backpressure, mid-operation reset and randomised operands.
module tb_cmp_arbiter_seq;
    localparam int WIDTH = 16;
    localparam int NREQ  = 4;
    localparam int NNIB  = WIDTH / 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] dbg_state;
    logic [1:0] dbg_rr;

    always #5 clk = ~clk;

    cmp_arbiter_seq_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus ();

    cmp_arbiter_seq #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .dbg_state_o  (dbg_state),
        .dbg_rr_ptr_o (dbg_rr)
    );

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;
    int acc_cnt = 0;
    bit prev_v  = 1'b0;
    bit rnd_en  = 1'b0;

    logic [4:0] exp_q[$];
    int         lat_q[$];
    int         gnt_q[$];

    logic [NREQ-1:0]  mon_acc;
    int               mon_g;
    logic [WIDTH-1:0] mon_a;
    logic [WIDTH-1:0] mon_b;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (rnd_en) begin
            #1 bus.rsp_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        else n_pass++;
    endtask

    function automatic int exp_m(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        for (int n = NNIB - 1; n >= 0; n--) begin
            if (a[n*4 +: 4] != b[n*4 +: 4]) return NNIB - n;
        end
        return NNIB;
    endfunction

    // Monitor: pushes expectations at accept, checks latency at rise and result at handshake.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            lat_q.delete();
            prev_v = 1'b0;
        end else begin
            mon_acc = bus.req_valid & bus.req_ready;
            if (mon_acc != '0) begin
                acc_cnt++;
                check("ready_onehot", 32'($onehot(bus.req_ready)), 1);
                mon_g = 0;
                for (int i = 0; i < NREQ; i++) if (mon_acc[i]) mon_g = i;
                if (gnt_q.size() > 0) check("grant_id", mon_g, gnt_q.pop_front());
                else check("grant_unexp", mon_g, 32'hFF);
                mon_a = bus.req_a[mon_g*WIDTH +: WIDTH];
                mon_b = bus.req_b[mon_g*WIDTH +: WIDTH];
                exp_q.push_back({2'(mon_g), mon_a > mon_b, mon_a == mon_b, mon_a < mon_b});
                lat_q.push_back(cyc + 1 + exp_m(mon_a, mon_b));
            end
            if (bus.rsp_valid && !prev_v) begin
                if (lat_q.size() > 0) check("latency", cyc, lat_q.pop_front());
                else check("rsp_unexp", bus.rsp_valid, 0);
            end
            if (bus.rsp_valid && bus.rsp_ready) begin
                if (exp_q.size() > 0)
                    check("result", {bus.rsp_id, bus.rsp_agb, bus.rsp_aeb, bus.rsp_alb}, exp_q.pop_front());
                else check("hs_unexp", bus.rsp_valid, 0);
            end
            prev_v = bus.rsp_valid;
        end
    end

    task automatic set_op(input int id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        bus.req_a[id*WIDTH +: WIDTH] = a;
        bus.req_b[id*WIDTH +: WIDTH] = b;
    endtask

    task automatic wait_acc(input int target, input int budget);
        int i = 0;
        do begin
            @(posedge clk);
            i++;
        end while (acc_cnt < target && i < budget);
        if (acc_cnt < target) check("acc_timeout", acc_cnt, target);
        #1;
    endtask

    task automatic drain(input int budget);
        int i = 0;
        do begin
            @(negedge clk);
            i++;
        end while (!(exp_q.size() == 0 && lat_q.size() == 0 && dbg_state == 2'd0) && i < budget);
        if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic single(input int id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        int base;
        base = acc_cnt;
        gnt_q.push_back(id);
        set_op(id, a, b);
        bus.req_valid = NREQ'(1) << id;
        wait_acc(base + 1, 30);
        bus.req_valid = '0;
        drain(60);
    endtask

    initial begin
        int base;
        int i;
        logic [WIDTH-1:0] ra, rb;
        bus.req_valid = '1;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b1;
        rst_n         = 1'b0;

        // Reset held with every requester asking
        gnt_q.push_back(0);
        repeat (3) begin
            @(negedge clk);
            check("rst_ready", bus.req_ready, 0);
            check("rst_valid", bus.rsp_valid, 0);
            check("rst_flags", {bus.rsp_agb, bus.rsp_aeb, bus.rsp_alb}, 0);
        end
        check("rst_id", bus.rsp_id, 0);
        check("rst_rr", dbg_rr, 0);
        base = acc_cnt;
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1 check("rel_ready", bus.req_ready, 4'b0001);
        wait_acc(base + 1, 20);
        bus.req_valid = '0;
        drain(60);

        // Early termination on the MSB nibble
        single(1, 16'h8000, 16'h7FFF);
        single(1, 16'h0000, 16'hFFFF);
        // Full and partial walks
        single(3, 16'h1234, 16'h1234);
        single(3, 16'h1230, 16'h1235);
        single(3, 16'h12F4, 16'h1204);

        // Round robin with every requester asking
        for (int r = 0; r < NREQ; r++) set_op(r, 16'h5A5A, 16'h5A5A);
        for (int r = 0; r < 8; r++) gnt_q.push_back(r % NREQ);
        base = acc_cnt;
        bus.req_valid = 4'b1111;
        wait_acc(base + 8, 200);
        bus.req_valid = '0;
        drain(60);
        gnt_q.push_back(0); gnt_q.push_back(1); gnt_q.push_back(3); gnt_q.push_back(0);
        base = acc_cnt;
        bus.req_valid = 4'b1011;
        wait_acc(base + 4, 120);
        bus.req_valid = '0;
        drain(60);

        // Backpressure with other requesters waiting
        gnt_q.push_back(3); gnt_q.push_back(0);
        set_op(3, 16'h00FF, 16'h0F00);
        bus.rsp_ready = 1'b0;
        base = acc_cnt;
        bus.req_valid = 4'b1000;
        wait_acc(base + 1, 30);
        bus.req_valid = 4'b0011;
        i = 0;
        do begin
            @(negedge clk);
            i++;
        end while (!bus.rsp_valid && i < 20);
        repeat (6) begin
            @(negedge clk);
            check("bp_valid", bus.rsp_valid, 1);
            check("bp_id", bus.rsp_id, 3);
            check("bp_flags", {bus.rsp_agb, bus.rsp_aeb, bus.rsp_alb}, 3'b001);
            check("bp_ready", bus.req_ready, 0);
        end
        @(posedge clk);
        #1 bus.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp_rsp_low", bus.rsp_valid, 0);
        check("bp_next_ready", bus.req_ready, 4'b0001);
        wait_acc(base + 2, 20);
        bus.req_valid = '0;
        drain(60);

        // Reset during the second compare cycle
        gnt_q.push_back(2);
        set_op(2, 16'h1234, 16'h1234);
        base = acc_cnt;
        bus.req_valid = 4'b0100;
        wait_acc(base + 1, 30);
        bus.req_valid = '0;
        @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("mid_valid", bus.rsp_valid, 0);
            check("mid_ready", bus.req_ready, 0);
        end
        check("mid_rr", dbg_rr, 0);
        check("mid_state", dbg_state, 0);
        for (int r = 0; r < NREQ; r++) set_op(r, 16'h0F0F, 16'h0F0F);
        gnt_q.push_back(0);
        base = acc_cnt;
        bus.req_valid = 4'b1111;
        @(posedge clk);
        #1 rst_n = 1'b1;
        wait_acc(base + 1, 20);
        bus.req_valid = '0;
        drain(60);

        // Randomised operands with random response backpressure
        rnd_en = 1'b1;
        for (int n = 0; n < 16; n++) begin
            ra = 16'($urandom_range(0, 16'hFFFF));
            case ($urandom_range(0, 2))
                0: rb = 16'($urandom_range(0, 16'hFFFF));
                1: rb = ra;
                default: rb = ra ^ (16'h1 << $urandom_range(0, WIDTH - 1));
            endcase
            single(int'($urandom_range(0, NREQ - 1)), ra, rb);
        end
        rnd_en = 1'b0;
        #2 bus.rsp_ready = 1'b1;
        drain(60);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
